// File: rtl/ft_cmd_pkg.sv
// Shared constants, header field layout and FSM encoding for the FT600
// command-frame engine.
package ft_cmd_pkg;

    localparam logic [7:0] SYNC_DEF      = 8'hA5;
    localparam logic [7:0] RESP_SYNC_DEF = 8'h5A;

    localparam logic [3:0] OP_WRLED  = 4'h1;
    localparam logic [3:0] OP_ECHO   = 4'h2;
    localparam logic [3:0] OP_STATUS = 4'h3;

    localparam int HDR_SYNC_LSB = 8;
    localparam int HDR_OP_LSB   = 4;
    localparam int HDR_LEN_LSB  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_WAIT,
        S_DECODE,
        S_PAY_POP,
        S_PAY_WAIT,
        S_PUSH,
        S_DONE
    } state_e;

    function automatic logic [15:0] resp_hdr(input logic [7:0] sync,
                                             input logic [3:0] op,
                                             input logic [3:0] len);
        return {sync, op, len};
    endfunction

endpackage

// File: rtl/ft_cmd_engine_if.sv
// RX/TX FIFO handshake between the command engine (master) and the FT600
// bridge user-side FIFOs (slave).
interface ft_cmd_engine_if;

    logic        rx_en;
    logic [15:0] rx_out;
    logic        rx_empty;
    logic        tx_en;
    logic [15:0] tx_in;
    logic        tx_full;

    modport master (
        output rx_en,
        input  rx_out,
        input  rx_empty,
        output tx_en,
        output tx_in,
        input  tx_full
    );

    modport slave (
        input  rx_en,
        output rx_out,
        output rx_empty,
        input  tx_en,
        input  tx_in,
        output tx_full
    );

endinterface

// File: rtl/ft_cmd_hdr_decode.sv
// Combinational split of a command header word into sync check, opcode,
// length and opcode-valid flag.
module ft_cmd_hdr_decode
    import ft_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC = SYNC_DEF
) (
    input  logic [15:0] hdr_i,
    output logic        sync_ok_o,
    output logic [3:0]  op_o,
    output logic [3:0]  len_o,
    output logic        op_valid_o
);

    assign sync_ok_o  = (hdr_i[HDR_SYNC_LSB +: 8] == SYNC);
    assign op_o       = hdr_i[HDR_OP_LSB +: 4];
    assign len_o      = hdr_i[HDR_LEN_LSB +: 4];
    assign op_valid_o = (op_o == OP_WRLED) || (op_o == OP_ECHO) || (op_o == OP_STATUS);

endmodule

// File: rtl/ft_cmd_engine.sv
// Command-frame engine: pops framed commands from the bridge RX FIFO, executes
// LED write / echo / status, and pushes responses into the bridge TX FIFO.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for a header word; rx_en while RX not empty
// HDR_WAIT   | popped header on rx_out; sync check, latch opcode/len
// DECODE     | load payload counter, pick action, stage response header
// PAY_POP    | waiting for a payload word; rx_en while RX not empty
// PAY_WAIT   | popped payload on rx_out; consume it, decrement counter
// PUSH       | tx_en while TX not full; holds tx_in while full
// DONE       | frame_done pulse
module ft_cmd_engine
    import ft_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC      = SYNC_DEF,
    parameter logic [7:0] RESP_SYNC = RESP_SYNC_DEF,
    parameter int         ERR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    ft_cmd_engine_if.master   bus,
    output logic [7:0]        led,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              frame_done
);

    state_e            state_q;
    logic [3:0]        op_q;
    logic [3:0]        len_q;
    logic [3:0]        cnt_q;
    logic              op_ok_q;
    logic              first_q;
    logic              stat_pend_q;
    logic              frame_done_q;
    logic [15:0]       tx_data_q;
    logic [15:0]       stat_word_q;
    logic [7:0]        led_q;
    logic [ERR_W-1:0]  err_cnt_q;

    logic [3:0]        cnt_d;
    logic [ERR_W-1:0]  err_cnt_d;

    logic              hdr_sync_ok;
    logic [3:0]        hdr_op;
    logic [3:0]        hdr_len;
    logic              hdr_op_valid;
    logic              pop;
    logic              push;

    ft_cmd_hdr_decode #(.SYNC(SYNC)) u_hdr_decode (
        .hdr_i      (bus.rx_out),
        .sync_ok_o  (hdr_sync_ok),
        .op_o       (hdr_op),
        .len_o      (hdr_len),
        .op_valid_o (hdr_op_valid)
    );

    // Strobes are qualified by the live FIFO flags so a pop or push can never
    // be issued against an empty/full FIFO, and both stay low during reset.
    assign pop  = rst && !bus.rx_empty && ((state_q == S_IDLE) || (state_q == S_PAY_POP));
    assign push = (state_q == S_PUSH) && !bus.tx_full;

    assign bus.rx_en = pop;
    assign bus.tx_en = push;
    assign bus.tx_in = tx_data_q;
    assign led        = led_q;
    assign err_cnt    = err_cnt_q;
    assign frame_done = frame_done_q;

    assign cnt_d     = cnt_q - 4'd1;
    assign err_cnt_d = (err_cnt_q == {ERR_W{1'b1}}) ? err_cnt_q : err_cnt_q + ERR_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            op_q         <= 4'd0;
            len_q        <= 4'd0;
            cnt_q        <= 4'd0;
            op_ok_q      <= 1'b0;
            first_q      <= 1'b0;
            stat_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
            tx_data_q    <= 16'd0;
            stat_word_q  <= 16'd0;
            led_q        <= 8'd0;
            err_cnt_q    <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) state_q <= S_HDR_WAIT;
                end
                S_HDR_WAIT: begin
                    op_q    <= hdr_op;
                    len_q   <= hdr_len;
                    op_ok_q <= hdr_op_valid;
                    if (!hdr_sync_ok) begin
                        err_cnt_q    <= err_cnt_d;
                        frame_done_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    cnt_q   <= len_q;
                    first_q <= 1'b1;
                    if (op_q == OP_ECHO) begin
                        tx_data_q <= resp_hdr(RESP_SYNC, OP_ECHO, len_q);
                        state_q   <= S_PUSH;
                    end else if (op_q == OP_STATUS) begin
                        // Snapshot taken before this frame's own error bump.
                        tx_data_q   <= resp_hdr(RESP_SYNC, OP_STATUS, 4'h1);
                        stat_word_q <= {err_cnt_q, led_q};
                        stat_pend_q <= 1'b1;
                        if (len_q != 4'd0) err_cnt_q <= err_cnt_d;
                        state_q <= S_PUSH;
                    end else begin
                        if (!op_ok_q) err_cnt_q <= err_cnt_d;
                        if (len_q == 4'd0) begin
                            frame_done_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            state_q <= S_PAY_POP;
                        end
                    end
                end
                S_PAY_POP: begin
                    if (pop) state_q <= S_PAY_WAIT;
                end
                S_PAY_WAIT: begin
                    cnt_q   <= cnt_d;
                    first_q <= 1'b0;
                    if (op_q == OP_ECHO) begin
                        tx_data_q <= bus.rx_out;
                        state_q   <= S_PUSH;
                    end else begin
                        if ((op_q == OP_WRLED) && first_q) led_q <= bus.rx_out[7:0];
                        if (cnt_d == 4'd0) begin
                            frame_done_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            state_q <= S_PAY_POP;
                        end
                    end
                end
                S_PUSH: begin
                    if (push) begin
                        if (stat_pend_q) begin
                            tx_data_q   <= stat_word_q;
                            stat_pend_q <= 1'b0;
                        end else if (cnt_q == 4'd0) begin
                            frame_done_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            state_q <= S_PAY_POP;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ft_cmd_engine.sv
// Scoreboard bench for ft_cmd_engine: a queue-backed RX FIFO model feeds
// directed frames, expected TX words are queued and checked by a monitor.
module tb_ft_cmd_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] led;
    logic [7:0] err_cnt;
    logic       frame_done;

    ft_cmd_engine_if bus();

    ft_cmd_engine dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .led        (led),
        .err_cnt    (err_cnt),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [15:0] rxq[$];
    logic [15:0] txq[$];
    int total   = 0;
    int bad     = 0;
    int frames  = 0;
    int tx_seen = 0;
    int rx_pops = 0;

    // RX FIFO model: data appears on rx_out the cycle after rx_en.
    initial begin : rx_fifo
        logic pop_seen;
        bus.rx_out   = 16'd0;
        bus.rx_empty = 1'b1;
        forever begin
            @(negedge clk);
            pop_seen = bus.rx_en;
            @(posedge clk);
            if (pop_seen) begin
                if (rxq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_underflow: rx_en=1 with %0d words queued, required rx_en=0", rxq.size());
                end else begin
                    bus.rx_out <= rxq.pop_front();
                end
            end
            bus.rx_empty <= (rxq.size() == 0);
        end
    end

    initial begin : monitor
        logic [15:0] exp_w;
        forever begin
            @(negedge clk);
            if (bus.tx_en) begin
                tx_seen++;
                total++;
                if (bus.tx_full) begin
                    bad++;
                    $display("FAIL tx_en_while_full: tx_full=%b, required tx_full=0 when tx_en=1", bus.tx_full);
                end
                total++;
                if (txq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_tx: got %h, required no push", bus.tx_in);
                end else begin
                    exp_w = txq.pop_front();
                    if (bus.tx_in !== exp_w) begin
                        bad++;
                        $display("FAIL tx_word: got %h required %h", bus.tx_in, exp_w);
                    end
                end
            end
            if (frame_done) frames++;
            if (bus.rx_en) rx_pops++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frames(input int target, input int budget, input string nm);
        int k;
        k = 0;
        while (frames < target && k < budget) begin
            step(1);
            k++;
        end
        chk(nm, frames, target);
    endtask

    task automatic wait_tx(input int target, input int budget, input string nm);
        int k;
        k = 0;
        while (tx_seen < target && k < budget) begin
            step(1);
            k++;
        end
        chk(nm, tx_seen, target);
    endtask

    initial begin : stim
        int base;
        int p0;
        int t0;
        bus.tx_full = 1'b0;

        // Reset with words already waiting: nothing may be popped.
        rxq.push_back(16'hA511);
        rxq.push_back(16'h003C);
        step(3);
        chk("rst_led", led, 8'h00);
        chk("rst_err", err_cnt, 8'h00);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_rx_en", bus.rx_en, 1'b0);
        chk("rst_tx_en", bus.tx_en, 1'b0);
        chk("rst_tx_in", bus.tx_in, 16'h0000);
        rst = 1'b1;

        // WRLED len=1
        wait_frames(1, 50, "wrled1_frames");
        chk("wrled1_led", led, 8'h3C);
        chk("wrled1_err", err_cnt, 8'h00);
        chk("wrled1_no_tx", tx_seen, 0);

        // WRLED len=0 leaves led alone
        base = frames;
        rxq.push_back(16'hA510);
        wait_frames(base + 1, 50, "wrled0_frames");
        chk("wrled0_led", led, 8'h3C);
        chk("wrled0_err", err_cnt, 8'h00);

        // WRLED len=3: only the first payload word lands
        base = frames;
        rxq.push_back(16'hA513);
        rxq.push_back(16'h0055);
        rxq.push_back(16'h00AA);
        rxq.push_back(16'h00FF);
        wait_frames(base + 1, 80, "wrled3_frames");
        chk("wrled3_led", led, 8'h55);
        chk("wrled3_rx_drained", rxq.size(), 0);

        // ECHO len=3
        base = frames;
        txq.push_back(16'h5A23);
        txq.push_back(16'h1111);
        txq.push_back(16'h2222);
        txq.push_back(16'h3333);
        rxq.push_back(16'hA523);
        rxq.push_back(16'h1111);
        rxq.push_back(16'h2222);
        rxq.push_back(16'h3333);
        wait_frames(base + 1, 100, "echo_frames");
        chk("echo_txq_empty", txq.size(), 0);

        // ECHO len=4 with TX full mid-stream
        base = frames;
        t0 = tx_seen;
        txq.push_back(16'h5A24);
        txq.push_back(16'h4444);
        txq.push_back(16'h5555);
        txq.push_back(16'h6666);
        txq.push_back(16'h7777);
        rxq.push_back(16'hA524);
        rxq.push_back(16'h4444);
        rxq.push_back(16'h5555);
        rxq.push_back(16'h6666);
        rxq.push_back(16'h7777);
        wait_tx(t0 + 2, 50, "stall_pre_tx");
        bus.tx_full = 1'b1;
        step(4);
        p0 = rx_pops;
        t0 = tx_seen;
        step(16);
        chk("stall_no_rx_en", rx_pops - p0, 0);
        chk("stall_no_tx_en", tx_seen - t0, 0);
        bus.tx_full = 1'b0;
        wait_frames(base + 1, 100, "stall_frames");
        chk("stall_txq_empty", txq.size(), 0);

        // Bad sync, unknown opcode with payload, then STATUS
        base = frames;
        txq.push_back(16'h5A31);
        txq.push_back(16'h0255);
        rxq.push_back(16'h0123);
        rxq.push_back(16'hA5F2);
        rxq.push_back(16'hAAAA);
        rxq.push_back(16'hBBBB);
        rxq.push_back(16'hA530);
        wait_frames(base + 3, 150, "err_frames");
        chk("err_cnt_two", err_cnt, 8'h02);
        chk("err_led_kept", led, 8'h55);
        chk("status_txq_empty", txq.size(), 0);

        // STATUS with payload: reports pre-increment count, then bumps it
        base = frames;
        txq.push_back(16'h5A31);
        txq.push_back(16'h0255);
        rxq.push_back(16'hA531);
        rxq.push_back(16'h9999);
        wait_frames(base + 1, 60, "status_len1_frames");
        chk("status_len1_err", err_cnt, 8'h03);
        chk("status_len1_txq_empty", txq.size(), 0);

        // Saturation
        base = frames;
        for (int i = 0; i < 300; i++) rxq.push_back(16'h0000);
        wait_frames(base + 300, 2000, "sat_frames");
        chk("sat_err", err_cnt, 8'hFF);
        chk("sat_led", led, 8'h55);

        // Reset in the middle of a len=5 WRLED frame
        base = frames;
        rxq.push_back(16'hA515);
        rxq.push_back(16'h0011);
        rxq.push_back(16'h0022);
        step(20);
        chk("mid_led", led, 8'h11);
        chk("mid_not_done", frames, base);
        #2 rst = 1'b0;
        #1;
        chk("arst_led", led, 8'h00);
        chk("arst_err", err_cnt, 8'h00);
        chk("arst_frame_done", frame_done, 1'b0);
        chk("arst_tx_in", bus.tx_in, 16'h0000);
        chk("arst_rx_en", bus.rx_en, 1'b0);
        rxq.push_back(16'h0033);
        rxq.push_back(16'h0044);
        rxq.push_back(16'h0055);
        step(3);
        chk("arst_hold_rx_en", bus.rx_en, 1'b0);
        rst = 1'b1;
        base = frames;
        wait_frames(base + 3, 60, "leftover_frames");
        chk("leftover_err", err_cnt, 8'h03);
        chk("leftover_led", led, 8'h00);
        chk("final_txq_empty", txq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
